// File: rtl/uc_multiciclo_if.sv
// Control/status bundle between the multicycle control unit and its datapath/host.
// The slave side is the control unit; the master side drives opcode, flags and run/step.
interface uc_multiciclo_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             zero;
    logic             run;
    logic             step;
    logic             s_inc;
    logic             s_inm;
    logic             we;
    logic             wez;
    logic [2:0]       ALUOp;
    logic             pc_we;
    logic             ir_we;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  Opcode, zero, run, step,
        output s_inc, s_inm, we, wez, ALUOp, pc_we, ir_we, busy, halted, instr_count
    );

    modport master (
        output Opcode, zero, run, step,
        input  s_inc, s_inm, we, wez, ALUOp, pc_we, ir_we, busy, halted, instr_count
    );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: IDLE/FETCH/EXEC/HALT sequencer with free-run and single-step,
// combinational EXEC decode and an executed-instruction counter.
module uc_multiciclo #(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    uc_multiciclo_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

    localparam logic [5:0] OP_J    = 6'b100000;
    localparam logic [5:0] OP_JZ   = 6'b100001;
    localparam logic [5:0] OP_JNZ  = 6'b100010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_e           state_q, state_d;
    logic             single_q, single_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;

    logic             s_inc_c, s_inm_c, we_c, wez_c, pc_we_c;
    logic [2:0]       alu_op_c;

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = FETCH;
                end else if (bus.step) begin
                    state_d  = FETCH;
                    single_d = 1'b1;
                end
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                if (bus.Opcode == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (single_q || !bus.run) begin
                        state_d  = IDLE;
                        single_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
        endcase
        busy_d   = (state_d == FETCH) || (state_d == EXEC);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    // EXEC decode sees the zero flag left by the previous instruction.
    always_comb begin
        s_inc_c  = 1'b1;
        s_inm_c  = 1'b0;
        we_c     = 1'b0;
        wez_c    = 1'b0;
        pc_we_c  = 1'b0;
        alu_op_c = 3'b000;
        if (state_q == EXEC) begin
            if (!bus.Opcode[5]) begin
                alu_op_c = bus.Opcode[3:1];
                s_inm_c  = bus.Opcode[4];
                we_c     = 1'b1;
                wez_c    = 1'b1;
                pc_we_c  = 1'b1;
            end else begin
                unique case (bus.Opcode)
                    OP_J: begin
                        s_inc_c = 1'b0;
                        pc_we_c = 1'b1;
                    end
                    OP_JZ: begin
                        s_inc_c = ~bus.zero;
                        pc_we_c = 1'b1;
                    end
                    OP_JNZ: begin
                        s_inc_c = bus.zero;
                        pc_we_c = 1'b1;
                    end
                    OP_HALT: pc_we_c = 1'b0;
                    default: pc_we_c = 1'b1;
                endcase
            end
        end
    end

    // Write enables are gated by reset so nothing lands in the datapath on the reset edge.
    assign bus.we          = we_c & reset;
    assign bus.wez         = wez_c & reset;
    assign bus.pc_we       = pc_we_c & reset;
    assign bus.ir_we       = (state_q == FETCH) & reset;
    assign bus.s_inc       = s_inc_c;
    assign bus.s_inm       = s_inm_c;
    assign bus.ALUOp       = alu_op_c;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = cnt_q;
endmodule
